pe_mac_simd: RTL and testbench

//  Next-gen systolic PE: LANES parallel 8-bit MACs share one west activation, each

---
 rtl/pe_pkg.sv | 38 +++
 rtl/pe_mac_lane.sv | 67 ++++++
 rtl/pe_mac_simd.sv | 135 +++++++++++++
 tb/tb_pe_mac_simd.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_pkg: shared widths, FSM state type and saturation bounds for pe_mac_simd
// Rev 1.0
// ---------------------------------------------------------------------------
package pe_pkg;

  localparam int PE_DW = 8;
  localparam int PE_AW = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pe_state_t;

  // Largest representable value of an aw-bit accumulator, LSB-aligned in 64 bits.
  function automatic logic [63:0] SAT_MAX(input int aw, input logic sgn);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < aw - (sgn ? 1 : 0)) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [63:0] SAT_MIN(input int aw, input logic sgn);
    logic [63:0] v;
    v = '0;
    if (sgn) begin
      for (int i = 0; i < 64; i++) begin
        if (i >= aw - 1) v[i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_mac_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_mac_lane: one lane multiply, extend and add; saturating when PE_SAT_EN
// Rev 1.0
// ---------------------------------------------------------------------------
module pe_mac_lane
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = PE_DW,
  parameter int ACCUM_WIDTH = PE_AW
) (
  input  logic                   sgn_i,
  input  logic [DATA_WIDTH-1:0]  n_i,
  input  logic [DATA_WIDTH-1:0]  w_i,
  input  logic [ACCUM_WIDTH-1:0] acc_i,
  output logic [ACCUM_WIDTH-1:0] sum_o,
  output logic                   sat_o
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACCUM_WIDTH;

  logic [2*DW-1:0] prod_u;
  logic [2*DW-1:0] prod_s;
  logic [AW-1:0]   ext;

  // Operands pre-extended to the product width so the low 2*DW bits are exact.
  assign prod_u = {{DW{1'b0}}, n_i} * {{DW{1'b0}}, w_i};
  assign prod_s = {{DW{n_i[DW-1]}}, n_i} * {{DW{w_i[DW-1]}}, w_i};

  if (AW > 2*DW) begin : g_ext_wide
    assign ext = sgn_i ? {{(AW-2*DW){prod_s[2*DW-1]}}, prod_s}
                       : {{(AW-2*DW){1'b0}}, prod_u};
  end else begin : g_ext_exact
    assign ext = sgn_i ? prod_s : prod_u;
  end

`ifdef PE_SAT_EN
  localparam logic [63:0] SMAX64 = SAT_MAX(AW, 1'b1);
  localparam logic [63:0] SMIN64 = SAT_MIN(AW, 1'b1);
  localparam logic [63:0] UMAX64 = SAT_MAX(AW, 1'b0);

  logic [AW:0] sum_w;

  assign sum_w = sgn_i ? ({acc_i[AW-1], acc_i} + {ext[AW-1], ext})
                       : ({1'b0, acc_i} + {1'b0, ext});

  always_comb begin
    sum_o = sum_w[AW-1:0];
    sat_o = 1'b0;
    if (sgn_i) begin
      if (sum_w[AW] != sum_w[AW-1]) begin
        sat_o = 1'b1;
        sum_o = sum_w[AW] ? SMIN64[AW-1:0] : SMAX64[AW-1:0];
      end
    end else if (sum_w[AW]) begin
      sat_o = 1'b1;
      sum_o = UMAX64[AW-1:0];
    end
  end
`else
  assign sum_o = acc_i + ext;
  assign sat_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/pe_mac_simd.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_mac_simd: SIMD systolic MAC PE with shadow result and drain chain.
// Optional saturating accumulation: define PE_SAT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module pe_mac_simd
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = PE_DW,
  parameter int ACCUM_WIDTH = PE_AW,
  parameter int LANES       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic                         last_in,
  input  logic                         signed_in,
  input  logic [LANES*DATA_WIDTH-1:0]  inp_north,
  input  logic [DATA_WIDTH-1:0]        inp_west,
  output logic [LANES*DATA_WIDTH-1:0]  outp_south,
  output logic [DATA_WIDTH-1:0]        outp_east,
  output logic                         valid_out,
  output logic                         last_out,
  output logic                         signed_out,
  input  logic [LANES*ACCUM_WIDTH-1:0] drain_in,
  input  logic                         drain_vld_in,
  input  logic                         drain_shift,
  input  logic                         drain_load,
  output logic [LANES*ACCUM_WIDTH-1:0] drain_out,
  output logic                         drain_vld_out,
  output logic                         overrun,
  output logic                         sat_flag
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACCUM_WIDTH;
  localparam int VW = LANES*AW;

  logic [VW-1:0]       acc_q, acc_d, shadow_q, shadow_d, drain_q, drain_d, w_sum;
  logic                full_q, full_d, dvld_q, dvld_d, ovr_q, ovr_d, sat_q, sat_d;
  logic [LANES-1:0]    w_sat;
  pe_state_t           state_q, state_d;
  logic [LANES*DW-1:0] south_q;
  logic [DW-1:0]       east_q;
  logic                vld_q, last_q, sgn_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pe_mac_lane #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW)) u_lane (
      .sgn_i (signed_in),
      .n_i   (inp_north[l*DW +: DW]),
      .w_i   (inp_west),
      .acc_i (acc_q[l*AW +: AW]),
      .sum_o (w_sum[l*AW +: AW]),
      .sat_o (w_sat[l])
    );
  end

  always_comb begin
    acc_d    = acc_q;
    shadow_d = shadow_q;
    full_d   = full_q;
    drain_d  = drain_q;
    dvld_d   = dvld_q;
    ovr_d    = ovr_q;
    sat_d    = sat_q;
    state_d  = state_q;
    if (valid_in) begin
      sat_d = sat_q | (|w_sat);
      if (last_in) begin
        shadow_d = w_sum;
        acc_d    = '0;
        state_d  = IDLE;
        if (full_q && !drain_load) ovr_d = 1'b1;
      end else begin
        acc_d   = w_sum;
        state_d = ACCUM;
      end
    end
    // The drain register always takes the pre-update shadow; a new tile
    // result arriving in the same cycle refills the shadow behind it.
    if (drain_load) begin
      drain_d = shadow_q;
      dvld_d  = full_q;
      full_d  = 1'b0;
    end else if (drain_shift) begin
      drain_d = drain_in;
      dvld_d  = drain_vld_in;
    end
    if (valid_in && last_in) full_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      shadow_q <= '0;
      full_q   <= 1'b0;
      drain_q  <= '0;
      dvld_q   <= 1'b0;
      ovr_q    <= 1'b0;
      sat_q    <= 1'b0;
      state_q  <= IDLE;
      south_q  <= '0;
      east_q   <= '0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      sgn_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      full_q   <= full_d;
      drain_q  <= drain_d;
      dvld_q   <= dvld_d;
      ovr_q    <= ovr_d;
      sat_q    <= sat_d;
      state_q  <= state_d;
      south_q  <= inp_north;
      east_q   <= inp_west;
      vld_q    <= valid_in;
      last_q   <= last_in;
      sgn_q    <= signed_in;
    end
  end

  assign outp_south    = south_q;
  assign outp_east     = east_q;
  assign valid_out     = vld_q;
  assign last_out      = last_q;
  assign signed_out    = sgn_q;
  assign drain_out     = drain_q;
  assign drain_vld_out = dvld_q;
  assign overrun       = ovr_q;
  assign sat_flag      = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_simd.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pe_mac_simd: 4-PE drain column plus a 16-bit single-lane PE.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pe_mac_simd;

  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int L   = 2;
  localparam int NPE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, last, sgn, dload, dshift, v16;
  logic [7:0]  west, n16;
  logic [15:0] north  [NPE];
  logic [63:0] dr_in  [NPE];
  logic [63:0] dr_out [NPE];
  logic        dv_in  [NPE];
  logic        dv_out [NPE];
  logic [15:0] south  [NPE];
  logic [7:0]  east   [NPE];
  logic        vo [NPE], lo [NPE], so [NPE], ov [NPE], sf [NPE];

  logic [7:0]  s16, e16;
  logic [15:0] d16;
  logic        vo16, lo16, so16, dv16, ov16, sf16;

  assign dr_in[0] = '0;
  assign dv_in[0] = 1'b0;

  for (genvar k = 0; k < NPE; k++) begin : g_pe
    if (k > 0) begin : g_link
      assign dr_in[k] = dr_out[k-1];
      assign dv_in[k] = dv_out[k-1];
    end
    pe_mac_simd #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .LANES(L)) u_dut (
      .clk(clk), .rst(rst), .valid_in(valid), .last_in(last), .signed_in(sgn),
      .inp_north(north[k]), .inp_west(west), .outp_south(south[k]), .outp_east(east[k]),
      .valid_out(vo[k]), .last_out(lo[k]), .signed_out(so[k]),
      .drain_in(dr_in[k]), .drain_vld_in(dv_in[k]), .drain_shift(dshift),
      .drain_load(dload), .drain_out(dr_out[k]), .drain_vld_out(dv_out[k]),
      .overrun(ov[k]), .sat_flag(sf[k])
    );
  end

  pe_mac_simd #(.DATA_WIDTH(DW), .ACCUM_WIDTH(16), .LANES(1)) u_dut16 (
    .clk(clk), .rst(rst), .valid_in(v16), .last_in(last), .signed_in(sgn),
    .inp_north(n16), .inp_west(west), .outp_south(s16), .outp_east(e16),
    .valid_out(vo16), .last_out(lo16), .signed_out(so16),
    .drain_in(16'd0), .drain_vld_in(1'b0), .drain_shift(dshift),
    .drain_load(dload), .drain_out(d16), .drain_vld_out(dv16),
    .overrun(ov16), .sat_flag(sf16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 1'b0; last = 1'b0; sgn = 1'b0; dload = 1'b0; dshift = 1'b0;
    v16 = 1'b0; west = '0; n16 = '0;
    for (int k = 0; k < NPE; k++) north[k] = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v, l, s;
    logic [7:0]  n0, n1, w;
    logic        ld, sh, c;
    logic [63:0] ed;
    logic        ev, eo;
  } vec_t;

  function automatic vec_t mk(input logic v, l, s, input logic [7:0] n0, n1, w,
                              input logic ld, sh, c, input logic [63:0] ed,
                              input logic ev, eo);
    vec_t r;
    r.v = v; r.l = l; r.s = s; r.n0 = n0; r.n1 = n1; r.w = w;
    r.ld = ld; r.sh = sh; r.c = c; r.ed = ed; r.ev = ev; r.eo = eo;
    return r;
  endfunction

  vec_t tbl [18];
  logic [63:0] exp_d;
  logic        exp_v;

  initial begin
    // Expected drain words are {lane1, lane0}.
    tbl[0]  = mk(1,0,0, 8'd2,  8'd1, 8'd5,  0,0,0, 64'd0, 0,0);
    tbl[1]  = mk(1,0,0, 8'd3,  8'd1, 8'd5,  0,0,0, 64'd0, 0,0);
    tbl[2]  = mk(1,1,0, 8'd4,  8'd1, 8'd5,  0,0,0, 64'd0, 0,0);
    tbl[3]  = mk(0,0,0, 8'd0,  8'd0, 8'd0,  1,0,1, {32'd15, 32'd45}, 1,0);
    tbl[4]  = mk(1,1,1, 8'hFD, 8'h80, 8'd7, 0,0,0, 64'd0, 0,0);
    tbl[5]  = mk(0,0,0, 8'd0,  8'd0, 8'd0,  1,0,1, {32'hFFFFFC80, 32'hFFFFFFEB}, 1,0);
    tbl[6]  = mk(1,1,0, 8'd2,  8'd1, 8'd5,  0,0,0, 64'd0, 0,0);
    tbl[7]  = mk(1,1,0, 8'd4,  8'd3, 8'd5,  1,0,1, {32'd5, 32'd10}, 1,0);
    tbl[8]  = mk(0,0,0, 8'd0,  8'd0, 8'd0,  1,0,1, {32'd15, 32'd20}, 1,0);
    tbl[9]  = mk(1,1,0, 8'd1,  8'd0, 8'd3,  0,0,0, 64'd0, 0,0);
    tbl[10] = mk(1,1,0, 8'd2,  8'd1, 8'd3,  0,0,1, {32'd15, 32'd20}, 1,1);
    tbl[11] = mk(0,0,0, 8'd0,  8'd0, 8'd0,  1,0,1, {32'd3, 32'd6}, 1,1);
    tbl[12] = mk(0,0,0, 8'd0,  8'd0, 8'd0,  1,0,1, {32'd3, 32'd6}, 0,1);
    tbl[13] = mk(1,0,0, 8'd10, 8'd1, 8'd10, 0,0,0, 64'd0, 0,0);
    tbl[14] = mk(0,0,0, 8'd99, 8'd99, 8'd99, 0,0,0, 64'd0, 0,0);
    tbl[15] = mk(1,1,0, 8'd1,  8'd1, 8'd1,  0,0,0, 64'd0, 0,0);
    tbl[16] = mk(0,0,0, 8'd0,  8'd0, 8'd0,  1,0,1, {32'd11, 32'd101}, 1,1);
    tbl[17] = mk(0,0,0, 8'd0,  8'd0, 8'd0,  0,1,1, 64'd0, 0,1);

    do_reset();
    chk("rst_drain",  dr_out[0], 64'd0);
    chk("rst_dvld",   64'(dv_out[0]), 64'd0);
    chk("rst_ovr",    64'(ov[0]), 64'd0);
    chk("rst_sat",    64'(sf[0]), 64'd0);
    chk("rst_south",  64'(south[0]), 64'd0);
    chk("rst_ctl",    64'({vo[0], lo[0], so[0]}), 64'd0);
    chk("rst_d16",    64'(d16), 64'd0);

    // Passthrough is registered regardless of valid_in.
    north[0] = 16'hA55A; west = 8'h3C; last = 1'b1; sgn = 1'b1;
    step();
    chk("pass_south", 64'(south[0]), 64'h0000_0000_0000_A55A);
    chk("pass_east",  64'(east[0]), 64'h3C);
    chk("pass_ctl",   64'({vo[0], lo[0], so[0]}), 64'b011);
    idle_inputs();
    step();

    for (int i = 0; i < 18; i++) begin
      valid = tbl[i].v; last = tbl[i].l; sgn = tbl[i].s; west = tbl[i].w;
      dload = tbl[i].ld; dshift = tbl[i].sh;
      for (int k = 0; k < NPE; k++) north[k] = {tbl[i].n1, tbl[i].n0};
      step();
      if (tbl[i].c) begin
        chk($sformatf("row%0d_drain", i), dr_out[0], tbl[i].ed);
        chk($sformatf("row%0d_dvld", i), 64'(dv_out[0]), 64'(tbl[i].ev));
        chk($sformatf("row%0d_ovr", i), 64'(ov[0]), 64'(tbl[i].eo));
      end
    end
    idle_inputs();
    chk("sat_clear32", 64'(sf[0]), 64'd0);

    // Column drain: one single-beat tile per PE, load all, then shift out.
    do_reset();
    for (int k = 0; k < NPE; k++) north[k] = {8'(10 + k), 8'(k + 1)};
    valid = 1'b1; last = 1'b1; west = 8'd1;
    step();
    valid = 1'b0; last = 1'b0; dload = 1'b1;
    step();
    dload = 1'b0;
    chk("chain_load", dr_out[NPE-1], {32'd13, 32'd4});
    chk("chain_load_vld", 64'(dv_out[NPE-1]), 64'd1);
    for (int s = 1; s <= NPE; s++) begin
      dshift = 1'b1;
      step();
      if (s < NPE) begin
        exp_d = {32'(13 - s), 32'(4 - s)};
        exp_v = 1'b1;
      end else begin
        exp_d = 64'd0;
        exp_v = 1'b0;
      end
      chk($sformatf("chain_shift%0d", s), dr_out[NPE-1], exp_d);
      chk($sformatf("chain_shift%0d_vld", s), 64'(dv_out[NPE-1]), 64'(exp_v));
    end
    dshift = 1'b0;
    chk("chain_no_ovr", 64'(ov[NPE-1]), 64'd0);

    // 16-bit accumulator: 255*255 twice overflows.
    west = 8'd255; n16 = 8'd255; v16 = 1'b1;
    step();
    last = 1'b1;
    step();
    v16 = 1'b0; last = 1'b0; dload = 1'b1;
    step();
    dload = 1'b0;
`ifdef PE_SAT_EN
    chk("acc16_sum", 64'(d16), 64'd65535);
    chk("acc16_sat", 64'(sf16), 64'd1);
`else
    chk("acc16_sum", 64'(d16), 64'd64514);
    chk("acc16_sat", 64'(sf16), 64'd0);
`endif
    chk("acc16_vld", 64'(dv16), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
